// File: rtl/matmul_pkg.sv
// Shared definitions for the MATMUL/LSTM operand sequencing blocks:
// FSM state encoding and default geometry of the banked operand buffers.
package matmul_pkg;

    // Default element index width and bank geometry
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_SEL_WIDTH = 2;

    // Sequencer FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/bank_seq_ctrl.sv
// bank_seq_ctrl: walks element index 0..len-1 for one operand pass and
// presents each beat as index / bank select / row address so consecutive
// beats rotate across the operand banks.
//
// Handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_valid and all
// beat fields stay stable until that transfer happens (abort and rst are
// the only other ways out). out_ready may toggle freely.
module bank_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int SEL_WIDTH = DEF_SEL_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           len,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_idx,
    output logic [SEL_WIDTH-1:0]       out_bank,
    output logic [WIDTH-SEL_WIDTH-1:0] out_row,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [1:0]                 dbg_state
);

    // Bank select is a plain slice of the index, so the bank count must
    // match the select width exactly.
    if (NUM_BANKS != (1 << SEL_WIDTH)) begin : g_bad_cfg
        $error("bank_seq_ctrl: NUM_BANKS must equal 1 << SEL_WIDTH");
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_idx;
    logic [WIDTH-1:0] r_len_q;
    logic             r_done;
    logic             r_aborted;

    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] w_len_m1;
    logic             w_last;
    logic             w_hs;
    logic             w_valid;

    // len_q is never 0 while in RUN, so the wrap of len_q-1 at 0 is harmless
    assign w_len_m1 = r_len_q - {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_last   = (r_idx == w_len_m1);
    assign w_valid  = (r_state == ST_RUN);
    assign w_hs     = w_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort beats a same-cycle final handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_hs && w_last) begin
                    w_next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Index/length datapath and the registered completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_len_q   <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= (w_next_state == ST_FIN);
            r_aborted <= (r_state == ST_RUN) && abort;
            if (r_state == ST_IDLE && start) begin
                r_len_q <= len;
                r_idx   <= '0;
            end else if (r_state == ST_RUN && !abort && w_hs && !w_last) begin
                r_idx <= r_idx + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output decode; beat fields are forced to zero outside RUN
    always_comb begin
        out_valid = w_valid;
        out_idx   = w_valid ? r_idx : '0;
        out_last  = w_valid & w_last;
        out_bank  = out_idx[SEL_WIDTH-1:0];
        out_row   = out_idx[WIDTH-1:SEL_WIDTH];
        busy      = (r_state != ST_IDLE);
        done      = r_done;
        aborted   = r_aborted;
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_bank_seq_ctrl.sv
// Testbench for bank_seq_ctrl. Two instances share all inputs: the default
// 4-bank geometry and an 8-bank variant. The driver scripts each pass at
// transaction level, pushes expected beats into a queue and publishes the
// expected per-cycle control outputs; a negedge monitor compares.
module tb_bank_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] len;
    logic             abort;
    logic             out_ready;

    logic             out_valid, out_last, busy, done, aborted;
    logic [WIDTH-1:0] out_idx;
    logic [1:0]       out_bank;
    logic [WIDTH-3:0] out_row;
    logic [1:0]       dbg_state;

    logic             v8_valid, v8_last, v8_busy, v8_done, v8_aborted;
    logic [WIDTH-1:0] v8_idx;
    logic [2:0]       v8_bank;
    logic [WIDTH-4:0] v8_row;
    logic [1:0]       v8_dbg_state;

    bank_seq_ctrl #(.WIDTH(WIDTH), .NUM_BANKS(4), .SEL_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_bank(out_bank), .out_row(out_row), .out_last(out_last),
        .busy(busy), .done(done), .aborted(aborted), .dbg_state(dbg_state)
    );

    bank_seq_ctrl #(.WIDTH(WIDTH), .NUM_BANKS(8), .SEL_WIDTH(3)) dut8 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .out_valid(v8_valid), .out_ready(out_ready), .out_idx(v8_idx),
        .out_bank(v8_bank), .out_row(v8_row), .out_last(v8_last),
        .busy(v8_busy), .done(v8_done), .aborted(v8_aborted), .dbg_state(v8_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Expected per-cycle control outputs
    bit exp_valid = 1'b0;
    bit exp_busy  = 1'b0;
    bit exp_done  = 1'b0;
    bit exp_abt   = 1'b0;

    // Expected beats: {last, idx}
    logic [WIDTH:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit v, input bit b, input bit d, input bit a);
        exp_valid = v;
        exp_busy  = b;
        exp_done  = d;
        exp_abt   = a;
    endtask

    // Monitor: control outputs every cycle, beat contents on each handshake
    always @(negedge clk) begin
        if (chk_en) begin
            logic [WIDTH:0] b;
            int bi;
            chk("valid", 32'(out_valid), 32'(exp_valid));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("aborted", 32'(aborted), 32'(exp_abt));
            chk("valid8", 32'(v8_valid), 32'(exp_valid));
            chk("done8", 32'(v8_done), 32'(exp_done));
            chk("aborted8", 32'(v8_aborted), 32'(exp_abt));
            if (!out_valid) begin
                chk("idle_idx", 32'(out_idx), 32'd0);
                chk("idle_bank", 32'(out_bank), 32'd0);
                chk("idle_row", 32'(out_row), 32'd0);
                chk("idle_last", 32'(out_last), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    b  = exp_q.pop_front();
                    bi = int'(b[WIDTH-1:0]);
                    chk("idx", 32'(out_idx), 32'(bi));
                    chk("bank", 32'(out_bank), 32'(bi % 4));
                    chk("row", 32'(out_row), 32'(bi / 4));
                    chk("last", 32'(out_last), 32'(b[WIDTH]));
                    chk("idx8", 32'(v8_idx), 32'(bi));
                    chk("bank8", 32'(v8_bank), 32'(bi % 8));
                    chk("row8", 32'(v8_row), 32'(bi / 8));
                    chk("last8", 32'(v8_last), 32'(b[WIDTH]));
                end
            end
        end
    end

    // One pass from IDLE. abort_at / rst_at: beat number at which to hit
    // abort or rst (-1 = never). stall: percent of cycles with ready low.
    // pat: ready pattern 1,0,0,1 repeating. poke: pulse start mid-pass/in FIN.
    task automatic run_pass(input int l, input int abort_at, input int rst_at,
                            input int stall, input bit pat, input bit poke);
        int h;
        int c;
        bit r;
        bit ab;
        bit rs;
        start = 1'b1;
        len   = WIDTH'(l);
        tick();
        start = 1'b0;
        len   = WIDTH'($urandom);
        if (l == 0) begin
            set_exp(1'b0, 1'b1, 1'b1, 1'b0);
        end else begin
            h = 0;
            c = 0;
            while (h < l) begin
                set_exp(1'b1, 1'b1, 1'b0, 1'b0);
                if (c > 2000) begin
                    fail_now("pass_timeout");
                    return;
                end
                ab = (h == abort_at);
                rs = (h == rst_at);
                if (pat) r = (c % 4 == 0) || (c % 4 == 3);
                else     r = ($urandom_range(0, 99) >= stall);
                if (ab) r = 1'b1;
                if (rs) r = 1'b0;
                out_ready = r;
                abort     = ab;
                rst       = rs;
                if (poke && !ab && !rs) begin
                    start = 1'($urandom_range(0, 1));
                    len   = WIDTH'($urandom);
                end
                if (r) exp_q.push_back({(h == l - 1) ? 1'b1 : 1'b0, WIDTH'(h)});
                tick();
                abort = 1'b0;
                rst   = 1'b0;
                start = 1'b0;
                c++;
                if (ab || rs) begin
                    set_exp(1'b0, 1'b0, 1'b0, ab);
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
                    return;
                end
                if (r) h++;
            end
            set_exp(1'b0, 1'b1, 1'b1, 1'b0);
        end
        out_ready = 1'($urandom_range(0, 1));
        if (poke) begin
            start = 1'b1;
            len   = WIDTH'($urandom_range(1, 9));
        end
        tick();
        start = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        tick();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_pass(6, -1, -1, 0, 1'b0, 1'b0);    // full throughput
        run_pass(8, -1, -1, 0, 1'b1, 1'b0);    // ready 1,0,0,1 stalls
        run_pass(0, -1, -1, 0, 1'b0, 1'b0);    // empty pass
        run_pass(10, 3, -1, 0, 1'b0, 1'b0);    // abort on 4th beat
        run_pass(2, -1, -1, 0, 1'b0, 1'b0);
        run_pass(7, -1, -1, 30, 1'b0, 1'b1);   // start poked in RUN and FIN
        run_pass(0, -1, -1, 0, 1'b0, 1'b1);
        run_pass(5, -1, 3, 0, 1'b0, 1'b0);     // reset after idx 2
        run_pass(12, -1, -1, 20, 1'b0, 1'b0);  // reaches idx 9 on 8 banks

        for (int i = 0; i < 25; i++) begin
            int l;
            int ab;
            l  = $urandom_range(0, 20);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_pass(l, ab, -1, $urandom_range(0, 60), 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bank_seq_ctrl.md
# bank_seq_ctrl

Sequencer that walks a linear element index 0..len-1 for one MATMUL/LSTM operand pass, emitting per-beat index, bank select and row address over a valid/ready handshake. Bank select is index mod NUM_BANKS (low SEL_WIDTH bits); row is index / NUM_BANKS. Sits between the layer controller (start/len/done) and the banked operand buffers, so consecutive beats rotate across banks.

## Interface
- WIDTH, 16: element index and length width
- NUM_BANKS, 4: bank count; power of 2, ≥2
- SEL_WIDTH, 2: log2(NUM_BANKS)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a pass; sampled only in IDLE
- len  in  WIDTH  element count for the pass; latched on accepted start
- abort  in  1  terminate current pass
- out_valid  out  1  beat present
- out_ready  in  1  consumer accepts beat
- out_idx  out  WIDTH  current element index
- out_bank  out  SEL_WIDTH  out_idx[SEL_WIDTH-1:0]
- out_row  out  WIDTH-SEL_WIDTH  out_idx[WIDTH-1:SEL_WIDTH]
- out_last  out  1  out_idx == len_q-1 while out_valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, pass completed normally
- aborted  out  1  one-cycle pulse, pass terminated by abort

## Operation
- States: IDLE, RUN, FIN.
- IDLE: start=1 → latch len_q=len, idx=0. len≠0 → RUN; len=0 → FIN (no beats emitted).
- RUN: out_valid=1, out_idx=idx. Handshake = out_valid & out_ready. On handshake with out_last=0 → idx+1; with out_last=1 → FIN. No handshake → all outputs held stable.
- FIN: done=1 for exactly one cycle → IDLE. start ignored in FIN.
- abort=1 in RUN → IDLE next cycle, aborted=1 that cycle, no done; abort has priority over a same-cycle handshake (beat still counts as transferred by the consumer; controller just stops). abort in IDLE/FIN ignored.
- start while busy ignored; len changes after latch ignored.
- Index never wraps: len max 2^WIDTH-1, last index len-1.
- out_bank/out_row are pure slices of out_idx; no inversion.
- Outputs out_idx/out_bank/out_row/out_last are 0 whenever out_valid=0.

## Timing
- Reset: state=IDLE, idx=0, len_q=0; out_valid, out_last, busy, done, aborted all 0; out_idx/out_bank/out_row 0. Reset mid-pass aborts silently (no aborted pulse).
- start accepted cycle N → out_valid=1, out_idx=0 at N+1.
- Full throughput: one beat per cycle with out_ready held high; len beats occupy N+1..N+len, done at N+len+1, busy falls at N+len+2, next start accepted at N+len+2.
- len=0: done at N+1.
- abort at cycle M (RUN) → aborted=1, busy=0, out_valid=0 at M+1.
- out_valid never drops without handshake or abort/rst (AXI-style stability).

## Structure
- Shared package (matmul_pkg): state encoding constants ST_IDLE/ST_RUN/ST_FIN (2-bit), default WIDTH/NUM_BANKS/SEL_WIDTH.
- No sub-module required; bank/row split is wiring. Optional elaboration check NUM_BANKS == 1<<SEL_WIDTH.
- Registered: state, idx, len_q, done, aborted. out_* driven combinationally from state/idx/len_q.

## Test plan
- Reset then start, len=6, out_ready=1 → idx 0..5, bank 0,1,2,3,0,1, row 0,0,0,0,1,1, out_last only at idx 5, done one cycle after, busy low one cycle later.
- len=8, out_ready toggled 1,0,0,1,... → outputs held during stalls, exactly 8 handshakes, done once.
- len=0 → no out_valid, done at start+1.
- len=10, abort at 4th beat with out_ready=1 → aborted pulse next cycle, no done, out_valid=0, new start len=2 then runs idx 0..1.
- start pulsed during RUN with different len, and during FIN → ignored; pass length unchanged, no re-trigger.
- rst asserted mid-pass (len=5, after idx=2) → all outputs reset values next cycle, no done/aborted; NUM_BANKS=8/SEL_WIDTH=3, idx 9 → bank 1, row 1.
